// File: rtl/code2of5_encoder_tx_pkg.sv
// Shared definitions for the 2-of-5 encoder: code table, FSM states, widths.
// Codes are packed E1..E5 from MSB to LSB.
package code2of5_pkg;

    localparam int CODE_WIDTH = 5;
    localparam int DIGIT_MAX  = 9;

    localparam logic [CODE_WIDTH-1:0] CODE_TABLE [0:DIGIT_MAX] = '{
        5'b11000, 5'b01001, 5'b00110, 5'b10001, 5'b00011,
        5'b01010, 5'b10010, 5'b00101, 5'b01100, 5'b10100
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/code2of5_encoder_tx_if.sv
// Digit input handshake between a digit source (master) and the encoder (slave).
interface code2of5_encoder_tx_if;

    logic [3:0] digit;
    logic       in_valid;
    logic       in_ready;

    modport master (output digit, output in_valid, input in_ready);
    modport slave  (input digit, input in_valid, output in_ready);

endinterface

// File: rtl/code2of5_encoder_tx_lut.sv
// Combinational BCD digit to 2-of-5 code lookup with legality flag.
module code2of5_lut
    import code2of5_pkg::*;
(
    input  logic [3:0]            i_digit,
    output logic [CODE_WIDTH-1:0] o_code,
    output logic                  o_legal
);

    always_comb begin
        o_legal = (i_digit <= 4'(DIGIT_MAX));
        o_code  = '0;
        if (o_legal) begin
            o_code = CODE_TABLE[i_digit];
        end
    end

endmodule

// File: rtl/code2of5_encoder_tx.sv
// 2-of-5 digit encoder: registers the parallel code of each accepted digit and
// shifts it out serially (E1 first), each bit held BIT_CYCLES clocks, then one gap cycle.
module code2of5_encoder_tx
    import code2of5_pkg::*;
#(
    parameter int BIT_CYCLES = 1
)(
    input  logic clk,
    input  logic rst_n,
    code2of5_encoder_tx_if.slave s_if,
    output logic E1,
    output logic E2,
    output logic E3,
    output logic E4,
    output logic E5,
    output logic code_valid,
    output logic tx_bit,
    output logic tx_busy,
    output logic err
);

    localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);

    state_t                r_state;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_cyc_cnt;
    logic [CODE_WIDTH-1:0] r_code;
    logic [CODE_WIDTH-1:0] r_shift;
    logic                  r_code_valid;
    logic                  r_tx_bit;
    logic                  r_tx_busy;
    logic                  r_err;
    logic                  r_in_ready;

    logic [CODE_WIDTH-1:0] w_code;
    logic                  w_legal;
    logic                  w_fire;

    code2of5_lut u_lut (
        .i_digit (s_if.digit),
        .o_code  (w_code),
        .o_legal (w_legal)
    );

    assign w_fire = s_if.in_valid & r_in_ready;

    // in_ready is registered: it can only rise on a clock edge, which makes
    // reset release take effect synchronously at the first edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_cyc_cnt    <= '0;
            r_code       <= '0;
            r_shift      <= '0;
            r_code_valid <= 1'b0;
            r_tx_bit     <= 1'b0;
            r_tx_busy    <= 1'b0;
            r_err        <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_fire) begin
                        r_code       <= w_code;
                        r_code_valid <= 1'b1;
                        r_err        <= ~w_legal;
                        if (w_legal) begin
                            r_state    <= ST_SHIFT;
                            r_in_ready <= 1'b0;
                            r_tx_busy  <= 1'b1;
                            r_tx_bit   <= w_code[CODE_WIDTH-1];
                            r_shift    <= {w_code[CODE_WIDTH-2:0], 1'b0};
                            r_bit_cnt  <= '0;
                            r_cyc_cnt  <= '0;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_in_ready <= 1'b0;
                    if (r_cyc_cnt == LAST_CYC) begin
                        r_cyc_cnt <= '0;
                        if (r_bit_cnt == 3'd4) begin
                            r_state   <= ST_GAP;
                            r_bit_cnt <= '0;
                            r_tx_bit  <= 1'b0;
                            r_tx_busy <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx_bit  <= r_shift[CODE_WIDTH-1];
                            r_shift   <= {r_shift[CODE_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.in_ready = r_in_ready;
    assign {E1, E2, E3, E4, E5} = r_code;
    assign code_valid = r_code_valid;
    assign tx_bit     = r_tx_bit;
    assign tx_busy    = r_tx_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_code2of5_encoder_tx.sv
// Directed bench for code2of5_encoder_tx: one instance with BIT_CYCLES=1, one with 3.
module tb_code2of5_encoder_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    code2of5_encoder_tx_if if_a();
    code2of5_encoder_tx_if if_b();

    logic a_e1, a_e2, a_e3, a_e4, a_e5, a_cv, a_tx, a_busy, a_err;
    logic b_e1, b_e2, b_e3, b_e4, b_e5, b_cv, b_tx, b_busy, b_err;

    code2of5_encoder_tx #(.BIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .s_if(if_a),
        .E1(a_e1), .E2(a_e2), .E3(a_e3), .E4(a_e4), .E5(a_e5),
        .code_valid(a_cv), .tx_bit(a_tx), .tx_busy(a_busy), .err(a_err)
    );

    code2of5_encoder_tx #(.BIT_CYCLES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .s_if(if_b),
        .E1(b_e1), .E2(b_e2), .E3(b_e3), .E4(b_e4), .E5(b_e5),
        .code_valid(b_cv), .tx_bit(b_tx), .tx_busy(b_busy), .err(b_err)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    logic sel = 1'b0;

    // Expected codes, E1..E5, written out from the encoding table by hand
    logic [4:0] exp_tab [0:9] = '{
        5'b11000, 5'b01001, 5'b00110, 5'b10001, 5'b00011,
        5'b01010, 5'b10010, 5'b00101, 5'b01100, 5'b10100
    };

    function automatic logic [4:0] obs_code();
        return sel ? {b_e1, b_e2, b_e3, b_e4, b_e5} : {a_e1, a_e2, a_e3, a_e4, a_e5};
    endfunction
    function automatic logic obs_cv();   return sel ? b_cv : a_cv;               endfunction
    function automatic logic obs_tx();   return sel ? b_tx : a_tx;               endfunction
    function automatic logic obs_busy(); return sel ? b_busy : a_busy;           endfunction
    function automatic logic obs_err();  return sel ? b_err : a_err;             endfunction
    function automatic logic obs_rdy();  return sel ? if_b.in_ready : if_a.in_ready; endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d);
        if (sel) begin
            if_b.in_valid = v;
            if_b.digit    = d;
        end else begin
            if_a.in_valid = v;
            if_a.digit    = d;
        end
    endtask

    // Called one step after the accept edge; walks bits first_bit..4, the gap, then ready
    task automatic run_frame(input logic [4:0] code, input int bc, input int first_bit);
        for (int i = first_bit; i < 5; i++) begin
            for (int c = 0; c < bc; c++) begin
                check("tx_bit",    obs_tx(),   code[4-i]);
                check("tx_busy",   obs_busy(), 1);
                check("ready_low", obs_rdy(),  0);
                check("code_hold", obs_code(), code);
                tick();
            end
        end
        check("gap_tx",     obs_tx(),   0);
        check("gap_busy",   obs_busy(), 0);
        check("gap_ready",  obs_rdy(),  0);
        tick();
        check("ready_back", obs_rdy(),  1);
        check("idle_tx",    obs_tx(),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        if_a.in_valid = 1'b0; if_a.digit = 4'd0;
        if_b.in_valid = 1'b0; if_b.digit = 4'd0;

        // Reset state
        #2;
        check("rst_ready_a", obs_rdy(),  0);
        check("rst_code_a",  obs_code(), 0);
        check("rst_tx_a",    obs_tx(),   0);
        check("rst_busy_a",  obs_busy(), 0);
        check("rst_err_a",   obs_err(),  0);
        check("rst_cv_a",    obs_cv(),   0);
        sel = 1'b1;
        check("rst_ready_b", obs_rdy(),  0);
        sel = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rel_ready_pre", obs_rdy(), 0);
        tick();
        check("rel_ready_a", obs_rdy(), 1);
        sel = 1'b1;
        check("rel_ready_b", obs_rdy(), 1);
        sel = 1'b0;

        // Digit 2, BIT_CYCLES=1
        drive(1'b1, 4'd2);
        tick();
        drive(1'b0, 4'd2);
        check("d2_code", obs_code(), 5'b00110);
        check("d2_cv",   obs_cv(),   1);
        check("d2_err",  obs_err(),  0);
        run_frame(5'b00110, 1, 0);
        check("d2_cv_pulse", obs_cv(), 0);

        // Digits 0..9 back-to-back with in_valid held high
        for (int d = 0; d < 10; d++) begin
            drive(1'b1, 4'(d));
            check("b2b_ready", obs_rdy(), 1);
            tick();
            check("b2b_code",  obs_code(), exp_tab[d]);
            check("b2b_ones",  $countones(obs_code()), 2);
            check("b2b_cv",    obs_cv(), 1);
            if (d == 9) drive(1'b0, 4'd9);
            run_frame(exp_tab[d], 1, 0);
        end

        // Illegal digit 12, then 7 clears err
        drive(1'b1, 4'd12);
        tick();
        drive(1'b0, 4'd12);
        check("ill_code",  obs_code(), 0);
        check("ill_err",   obs_err(),  1);
        check("ill_busy",  obs_busy(), 0);
        check("ill_ready", obs_rdy(),  1);
        check("ill_tx",    obs_tx(),   0);
        tick();
        check("ill_busy2", obs_busy(), 0);
        check("ill_err2",  obs_err(),  1);
        drive(1'b1, 4'd7);
        tick();
        drive(1'b0, 4'd7);
        check("d7_code", obs_code(), 5'b00101);
        check("d7_err",  obs_err(),  0);
        check("d7_cv",   obs_cv(),   1);
        run_frame(5'b00101, 1, 0);

        // Digit 9 on the BIT_CYCLES=3 instance: 15 bit cycles plus gap
        sel = 1'b1;
        drive(1'b1, 4'd9);
        tick();
        drive(1'b0, 4'd9);
        check("bc3_code", obs_code(), 5'b10100);
        check("bc3_cv",   obs_cv(),   1);
        run_frame(5'b10100, 3, 0);
        sel = 1'b0;

        // Reset during the 3rd bit of digit 5, then a clean frame for 4
        drive(1'b1, 4'd5);
        tick();
        drive(1'b0, 4'd5);
        check("d5_code", obs_code(), 5'b01010);
        tick();
        tick();
        check("d5_bit3_tx",   obs_tx(),   0);
        check("d5_bit3_busy", obs_busy(), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_code",  obs_code(), 0);
        check("abort_tx",    obs_tx(),   0);
        check("abort_busy",  obs_busy(), 0);
        check("abort_err",   obs_err(),  0);
        check("abort_cv",    obs_cv(),   0);
        check("abort_ready", obs_rdy(),  0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rel2_ready", obs_rdy(),  1);
        check("rel2_tx",    obs_tx(),   0);
        check("rel2_busy",  obs_busy(), 0);
        drive(1'b1, 4'd4);
        tick();
        drive(1'b0, 4'd4);
        check("d4_code", obs_code(), 5'b00011);
        check("d4_cv",   obs_cv(),   1);
        run_frame(5'b00011, 1, 0);

        // Digit 8 presented (and changed) mid-frame is ignored until IDLE
        drive(1'b1, 4'd3);
        tick();
        drive(1'b1, 4'd8);
        check("d3_code",  obs_code(), 5'b10001);
        check("d3_tx0",   obs_tx(),   1);
        check("d3_ready", obs_rdy(),  0);
        tick();
        drive(1'b1, 4'd6);
        check("ign_code", obs_code(), 5'b10001);
        check("ign_tx1",  obs_tx(),   0);
        tick();
        drive(1'b1, 4'd8);
        run_frame(5'b10001, 1, 2);
        tick();
        drive(1'b0, 4'd8);
        check("d8_code", obs_code(), 5'b01100);
        check("d8_cv",   obs_cv(),   1);
        check("d8_err",  obs_err(),  0);
        run_frame(5'b01100, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
